// File: rtl/imem_boot_loader_if.sv
// Bundle between the host byte stream, the instruction-memory write port and
// the core hold line. The loader sits on the slave side.
interface imem_boot_loader_if #(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 32
) ();
    logic              start;
    logic [ADDR_W:0]   len;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, len, byte_in, byte_valid,
        input  byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err
    );

    modport slave (
        input  start, len, byte_in, byte_valid,
        output byte_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Packs a big-endian byte stream into 32-bit words and writes them to instruction
// memory from address 0, holding the core until the whole image is in place.
module imem_boot_loader #(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 32
) (
    input logic               clk,
    input logic               rst,
    imem_boot_loader_if.slave bus
);
    localparam int              NBYTES  = WORD_W / 8;
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(2 ** ADDR_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic [ADDR_W:0]   len_q;
    logic [WORD_W-1:0] word_q;
    logic              err_q;
    logic              hold_q;

    logic len_ok;
    logic xfer;
    logic last_byte;
    logic last_word;

    assign len_ok    = (bus.len != '0) && (bus.len <= MAX_LEN);
    assign xfer      = (state_q == S_RECV) && bus.byte_valid;
    assign last_byte = (byte_cnt_q == 2'(NBYTES - 1));
    // len_q is at least 1 whenever this is consulted, so the subtraction never wraps
    assign last_word = ({1'b0, word_idx_q} == (len_q - (ADDR_W + 1)'(1)));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start && len_ok) state_d = S_RECV;
            S_RECV:  if (xfer && last_byte)   state_d = S_WRITE;
            S_WRITE: state_d = last_word ? S_DONE : S_RECV;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            len_q      <= '0;
            word_q     <= '0;
            err_q      <= 1'b0;
            hold_q     <= 1'b1;
        end else begin
            err_q <= (state_q == S_IDLE) && bus.start && !len_ok;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && len_ok) begin
                        len_q      <= bus.len;
                        word_idx_q <= '0;
                        byte_cnt_q <= '0;
                        hold_q     <= 1'b1;
                    end
                end
                S_RECV: begin
                    // the counter wraps to 0 on the 4th byte, ready for the next word
                    if (xfer) begin
                        word_q     <= {word_q[WORD_W-9:0], bus.byte_in};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                end
                S_WRITE: begin
                    if (!last_word) word_idx_q <= word_idx_q + 1'b1;
                end
                S_DONE: hold_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // every output comes from the state register or a flop, never from an input
    assign bus.byte_ready = (state_q == S_RECV);
    assign bus.imem_we    = (state_q == S_WRITE);
    assign bus.imem_addr  = word_idx_q;
    assign bus.imem_wdata = word_q;
    assign bus.busy       = (state_q == S_RECV) || (state_q == S_WRITE);
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = err_q;
    assign bus.cpu_hold   = hold_q;
endmodule
